// File: rtl/maxpool2d_relu_stream.sv
// rtl/maxpool2d_relu_stream.sv - streaming 2x2 stride-2 float32 max-pool with optional fused ReLU
//
// Purpose:
//   Consumes a raster-order float32 feature-map stream of WIDTH x HEIGHT pixels
//   and emits the (WIDTH/2) x (HEIGHT/2) max-pooled stream in raster order.
//   Optional feature macro: MAXPOOL_RELU_EN (defined = ReLU fused on the output).
//
// Ports:
//   clk        in  1           rising-edge clock
//   rst        in  1           synchronous active-high reset
//   valid_in   in  1           data_in carries a pixel this cycle
//   data_in    in  DATA_WIDTH  input pixel (float32)
//   valid_out  out 1           data_out carries a pooled pixel (single-cycle pulse)
//   data_out   out DATA_WIDTH  pooled pixel (float32)
//   last_out   out 1           final pooled pixel of a frame

module maxpool2d_relu_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int HW = WIDTH / 2;
  localparam int AW = (HW > 1) ? $clog2(HW) : 1;

  // Sign-magnitude max; NaN/Inf are not expected. Differing signs: positive
  // operand wins (so +0 beats -0). Same sign: compare magnitudes directly.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] res;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      res = a[DATA_WIDTH-1] ? b : a;
    else if (!a[DATA_WIDTH-1])
      res = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    else
      res = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
    return res;
  endfunction

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_linebuf [HW];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_last_out;

  logic [AW-1:0]         w_addr;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [DATA_WIDTH-1:0] w_pair_max;
  logic [DATA_WIDTH-1:0] w_pool;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_addr     = AW'(r_col >> 1);
  assign w_col_last = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 1));
  // Horizontal pair max of the current row; on even rows it goes into the
  // line buffer, on odd rows it is combined with the stored upper pair.
  assign w_pair_max = fmax(r_hold, data_in);
  assign w_pool     = fmax(r_linebuf[w_addr], w_pair_max);

`ifdef MAXPOOL_RELU_EN
  // Any sign-bit-set result (including -0) becomes +0.
  assign w_result = w_pool[DATA_WIDTH-1] ? '0 : w_pool;
`else
  assign w_result = w_pool;
`endif

  // Every entry is written on an even row before being read on the next odd
  // row, so the buffer carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && valid_in && r_col[0] && !r_row[0])
      r_linebuf[w_addr] <= w_pair_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
      if (valid_in) begin
        if (!r_col[0]) begin
          r_hold <= data_in;
        end else if (r_row[0]) begin
          r_data_out  <= w_result;
          r_valid_out <= 1'b1;
          r_last_out  <= w_row_last && w_col_last;
        end

        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign last_out  = r_last_out;

endmodule
